mem_arbiter: RTL and testbench

//  Main-memory stage directly below the I-cache and D-cache. Accepts line-sized mem_req_t from both

---
 rtl/brisc_pkg.sv | 41 ++++
 rtl/mem_line_array.sv | 25 ++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
// Shared types and sizing for the brisc memory hierarchy.
// Line-sized request/response structs between caches and main memory.
package brisc_pkg;

  localparam int ADDR_LEN       = 32;
  localparam int WORD_LEN       = 32;
  localparam int CACHE_LINE_LEN = 128;
  localparam int OFFSET_LEN     = $clog2(CACHE_LINE_LEN / 8);

  localparam int MEM_REQ_DELAY  = 5;
  localparam int MEM_RESP_DELAY = 5;
  localparam int MEM_DEPTH      = 65536;
  localparam int MEM_LINES      = MEM_DEPTH / (CACHE_LINE_LEN / WORD_LEN);
  localparam int MEM_IDX_LEN    = $clog2(MEM_LINES);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ_WAIT,
    ARB_RESP_WAIT,
    ARB_RESP
  } mem_arb_state_e;

  typedef enum logic {
    ICACHE,
    DCACHE
  } mem_client_e;

  typedef struct packed {
    logic                      valid;
    logic                      rw;
    logic [ADDR_LEN-1:0]       addr;
    logic [CACHE_LINE_LEN-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic                      ready;
    logic [ADDR_LEN-1:0]       addr;
    logic [CACHE_LINE_LEN-1:0] data;
  } mem_resp_t;

endpackage

// File: rtl/mem_line_array.sv
// Single-port line-wide storage: synchronous write, registered read, one enable.
// Latency 1 cycle on read; no backpressure; contents are never reset.
module mem_line_array #(
  parameter int LINES = 16384,
  parameter int IDX_W = 14,
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [LINES];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[idx] <= wdata;
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Main memory below I/D caches: arbitrates two line requests onto one backing array.
// Latency REQ_DELAY+RESP_DELAY+1 cycles; one transaction in flight, losers wait with valid held.
// MEM_ARB_RR_EN selects round-robin tie-break; otherwise DCACHE has fixed priority.
module mem_arbiter
  import brisc_pkg::*;
#(
  parameter int REQ_DELAY   = MEM_REQ_DELAY,
  parameter int RESP_DELAY  = MEM_RESP_DELAY,
  parameter int DEPTH_WORDS = MEM_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  mem_req_t  icache_req_i,
  output mem_resp_t icache_resp_o,
  input  mem_req_t  dcache_req_i,
  output mem_resp_t dcache_resp_o,
  output logic      busy_o
);

  localparam int LINES    = DEPTH_WORDS / (CACHE_LINE_LEN / WORD_LEN);
  localparam int IDX_LEN  = $clog2(LINES);
  localparam int LINE_W   = ADDR_LEN - OFFSET_LEN;
  localparam int MAX_DLY  = (REQ_DELAY > RESP_DELAY) ? REQ_DELAY : RESP_DELAY;
  localparam int CNT_W    = $clog2(MAX_DLY + 1);

  mem_arb_state_e              state;
  logic [CNT_W-1:0]            cnt;
  mem_client_e                 lat_client;
  logic                        lat_rw;
  logic [LINE_W-1:0]           lat_line;
  logic [CACHE_LINE_LEN-1:0]   lat_data;
  logic [CACHE_LINE_LEN-1:0]   rd_data;

  logic                        grant_vld;
  mem_client_e                 grant;
  logic [ADDR_LEN-1:0]         g_addr;
  logic [CACHE_LINE_LEN-1:0]   g_data;
  logic                        g_rw;
  logic                        arr_en;

`ifdef MEM_ARB_RR_EN
  mem_client_e                 rr_ptr;
`endif

  always_comb begin
    grant_vld = icache_req_i.valid | dcache_req_i.valid;
    grant     = ICACHE;
    if (icache_req_i.valid && dcache_req_i.valid) begin
`ifdef MEM_ARB_RR_EN
      grant = rr_ptr;
`else
      grant = DCACHE;
`endif
    end else if (dcache_req_i.valid) begin
      grant = DCACHE;
    end
  end

  // The I-side is read-only: its rw bit never reaches the array.
  assign g_addr = (grant == DCACHE) ? dcache_req_i.addr : icache_req_i.addr;
  assign g_data = (grant == DCACHE) ? dcache_req_i.data : icache_req_i.data;
  assign g_rw   = (grant == DCACHE) & dcache_req_i.rw;

  assign arr_en = (state == ARB_REQ_WAIT) && (cnt == '0);
  assign busy_o = (state != ARB_IDLE);

  mem_line_array #(
    .LINES (LINES),
    .IDX_W (IDX_LEN),
    .WIDTH (CACHE_LINE_LEN)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_en & lat_rw),
    .idx   (lat_line[IDX_LEN-1:0]),
    .wdata (lat_data),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ARB_IDLE;
      cnt           <= '0;
      lat_client    <= DCACHE;
      lat_rw        <= 1'b0;
      lat_line      <= '0;
      lat_data      <= '0;
      icache_resp_o <= '0;
      dcache_resp_o <= '0;
`ifdef MEM_ARB_RR_EN
      rr_ptr        <= DCACHE;
`endif
    end else begin
      icache_resp_o.ready <= 1'b0;
      dcache_resp_o.ready <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_vld) begin
            lat_client <= grant;
            lat_rw     <= g_rw;
            lat_line   <= g_addr[ADDR_LEN-1:OFFSET_LEN];
            lat_data   <= g_data;
            cnt        <= CNT_W'(REQ_DELAY - 1);
            state      <= ARB_REQ_WAIT;
`ifdef MEM_ARB_RR_EN
            rr_ptr     <= (grant == DCACHE) ? ICACHE : DCACHE;
`endif
          end
        end
        ARB_REQ_WAIT: begin
          if (cnt == '0) begin
            cnt   <= CNT_W'(RESP_DELAY - 1);
            state <= ARB_RESP_WAIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ARB_RESP_WAIT: begin
          if (cnt == '0) begin
            state <= ARB_RESP;
            // A write returns the line it stored; the array read port shows the old line.
            if (lat_client == DCACHE) begin
              dcache_resp_o.ready <= 1'b1;
              dcache_resp_o.addr  <= {lat_line, {OFFSET_LEN{1'b0}}};
              dcache_resp_o.data  <= lat_rw ? lat_data : rd_data;
            end else begin
              icache_resp_o.ready <= 1'b1;
              icache_resp_o.addr  <= {lat_line, {OFFSET_LEN{1'b0}}};
              icache_resp_o.data  <= rd_data;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ARB_RESP: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, arbitration, wrap, reset behaviour.
module tb_mem_arbiter;
  import brisc_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  mem_req_t  ireq, dreq;
  mem_resp_t iresp, dresp;
  logic      busy;

  int tests = 0;
  int fails = 0;
  int i_rdy_cnt = 0;
  int d_rdy_cnt = 0;

  localparam logic [127:0] LINE_A = 128'h0123_4567_89AB_CDEF_0000_1111_DEAD_BEEF;
  localparam logic [127:0] LINE_B = 128'hB0B0_B0B0_1234_5678_CAFE_F00D_0BAD_BEEF;
  localparam logic [127:0] LINE_C = 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC;
  localparam logic [127:0] LINE_K = 128'h5555_AAAA_0F0F_F0F0_1357_9BDF_2468_ACE0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (iresp.ready) i_rdy_cnt++;
    if (dresp.ready) d_rdy_cnt++;
  end

  mem_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .icache_req_i  (ireq),
    .icache_resp_o (iresp),
    .dcache_req_i  (dreq),
    .dcache_resp_o (dresp),
    .busy_o        (busy)
  );

  // Drives one request, waits for its ready (bounded), then drops valid.
  task automatic do_req(input bit is_d, input bit rw, input logic [31:0] addr,
                        input logic [127:0] data, output int lat,
                        output mem_resp_t resp, output logic busy1);
    mem_req_t r;
    r.valid = 1'b1; r.rw = rw; r.addr = addr; r.data = data;
    @(negedge clk);
    if (is_d) dreq = r; else ireq = r;
    lat = 0; resp = '0; busy1 = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == 1) busy1 = busy;
      if (is_d ? dresp.ready : iresp.ready) begin
        lat  = c;
        resp = is_d ? dresp : iresp;
        break;
      end
    end
    if (is_d) dreq = '0; else ireq = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ireq = '0; dreq = '0;
    #12;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (iresp !== '0) begin fails++; $display("FAIL reset_iresp got=%h exp=0", iresp); end
    tests++; if (dresp !== '0) begin fails++; $display("FAIL reset_dresp got=%h exp=0", dresp); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_tie();
    int t_d1 = 0, t_i = 0, t_d2 = 0;
    bit d_second = 0;
    logic [31:0] i_addr = '0;
    mem_req_t r;
    @(negedge clk);
    r = '0; r.valid = 1'b1; r.addr = 32'h0000_4010; dreq = r;
    r.addr = 32'h0000_4004; ireq = r;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (dresp.ready) begin
        if (!d_second) begin t_d1 = c; d_second = 1; dreq.addr = 32'h0000_4020; end
        else begin t_d2 = c; dreq = '0; end
      end
      if (iresp.ready) begin t_i = c; i_addr = iresp.addr; ireq = '0; end
    end
    tests++; if (t_d1 !== 11) begin fails++; $display("FAIL tie_d1_latency got=%0d exp=11", t_d1); end
`ifdef MEM_ARB_RR_EN
    tests++; if (t_i !== 23) begin fails++; $display("FAIL tie_i_latency got=%0d exp=23", t_i); end
    tests++; if (t_d2 !== 35) begin fails++; $display("FAIL tie_d2_latency got=%0d exp=35", t_d2); end
`else
    tests++; if (t_d2 !== 23) begin fails++; $display("FAIL tie_d2_latency got=%0d exp=23", t_d2); end
    tests++; if (t_i !== 35) begin fails++; $display("FAIL tie_i_latency got=%0d exp=35", t_i); end
`endif
    tests++; if (i_addr !== 32'h0000_4000) begin fails++; $display("FAIL tie_i_addr got=%h exp=00004000", i_addr); end
  endtask

  task automatic test_write_read();
    int lat; mem_resp_t resp; logic b1; int icnt0;
    icnt0 = i_rdy_cnt;
    do_req(1'b1, 1'b1, 32'h0000_4000, LINE_A, lat, resp, b1);
    tests++; if (b1 !== 1'b1) begin fails++; $display("FAIL wr_busy got=%b exp=1", b1); end
    tests++; if (lat !== 11) begin fails++; $display("FAIL wr_latency got=%0d exp=11", lat); end
    tests++; if (resp.data !== LINE_A) begin fails++; $display("FAIL wr_data got=%h exp=%h", resp.data, LINE_A); end
    do_req(1'b1, 1'b0, 32'h0000_4008, '0, lat, resp, b1);
    tests++; if (lat !== 11) begin fails++; $display("FAIL rd_latency got=%0d exp=11", lat); end
    tests++; if (resp.data !== LINE_A) begin fails++; $display("FAIL rd_data got=%h exp=%h", resp.data, LINE_A); end
    tests++; if (resp.addr !== 32'h0000_4000) begin fails++; $display("FAIL rd_addr got=%h exp=00004000", resp.addr); end
    tests++; if (i_rdy_cnt !== icnt0) begin fails++; $display("FAIL wr_rd_iready got=%0d exp=%0d", i_rdy_cnt, icnt0); end
  endtask

  task automatic test_back_to_back();
    int t1 = 0, t2 = 0, cnt0, lat;
    bit second = 0;
    logic [31:0] a2 = '0;
    logic [127:0] d2 = '0;
    mem_req_t r; mem_resp_t resp; logic b1;
    do_req(1'b1, 1'b1, 32'h0000_4010, LINE_K, lat, resp, b1);
    cnt0 = d_rdy_cnt;
    @(negedge clk);
    r = '0; r.valid = 1'b1; r.addr = 32'h0000_4000; dreq = r;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (dresp.ready) begin
        if (!second) begin t1 = c; second = 1; dreq.addr = 32'h0000_4010; end
        else begin t2 = c; a2 = dresp.addr; d2 = dresp.data; dreq = '0; end
      end
    end
    tests++; if (t1 !== 11) begin fails++; $display("FAIL b2b_first got=%0d exp=11", t1); end
    tests++; if (t2 !== 23) begin fails++; $display("FAIL b2b_second got=%0d exp=23", t2); end
    tests++; if (d_rdy_cnt - cnt0 !== 2) begin fails++; $display("FAIL b2b_ready_count got=%0d exp=2", d_rdy_cnt - cnt0); end
    tests++; if (a2 !== 32'h0000_4010) begin fails++; $display("FAIL b2b_addr got=%h exp=00004010", a2); end
    tests++; if (d2 !== LINE_K) begin fails++; $display("FAIL b2b_data got=%h exp=%h", d2, LINE_K); end
  endtask

  task automatic test_icache_rw();
    int lat; mem_resp_t resp; logic b1;
    do_req(1'b1, 1'b1, 32'h0000_1000, LINE_B, lat, resp, b1);
    do_req(1'b0, 1'b1, 32'h0000_1000, {128{1'b1}}, lat, resp, b1);
    tests++; if (lat !== 11) begin fails++; $display("FAIL i_latency got=%0d exp=11", lat); end
    tests++; if (resp.data !== LINE_B) begin fails++; $display("FAIL i_rw_resp got=%h exp=%h", resp.data, LINE_B); end
    do_req(1'b1, 1'b0, 32'h0000_1000, '0, lat, resp, b1);
    tests++; if (resp.data !== LINE_B) begin fails++; $display("FAIL i_rw_array got=%h exp=%h", resp.data, LINE_B); end
  endtask

  task automatic test_reset_mid();
    int lat, cnt0; mem_resp_t resp; logic b1; mem_req_t r;
    do_req(1'b1, 1'b1, 32'h0000_2000, LINE_B, lat, resp, b1);
    @(negedge clk);
    r.valid = 1'b1; r.rw = 1'b1; r.addr = 32'h0000_2000; r.data = LINE_C; dreq = r;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    cnt0 = d_rdy_cnt;
    rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy_async got=%b exp=0", busy); end
    @(negedge clk); dreq = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    tests++; if (d_rdy_cnt !== cnt0) begin fails++; $display("FAIL mid_no_ready got=%0d exp=%0d", d_rdy_cnt, cnt0); end
    do_req(1'b1, 1'b0, 32'h0000_2000, '0, lat, resp, b1);
    tests++; if (resp.data !== LINE_B) begin fails++; $display("FAIL mid_line_kept got=%h exp=%h", resp.data, LINE_B); end
  endtask

  task automatic test_wrap();
    int lat; mem_resp_t resp; logic b1;
    do_req(1'b1, 1'b0, 32'h0000_4000 + MEM_DEPTH * 4, '0, lat, resp, b1);
    tests++; if (resp.data !== LINE_A) begin fails++; $display("FAIL wrap_data got=%h exp=%h", resp.data, LINE_A); end
    tests++; if (resp.addr !== 32'h0004_4000) begin fails++; $display("FAIL wrap_addr got=%h exp=00044000", resp.addr); end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_write_read();
    test_back_to_back();
    test_icache_rw();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
